ready_latency_table: RTL
========================

Name: ready_latency_table

Overview:
- Successor to the dispatch-time ready bit table.
- Tracks per-physical-register readiness with a latency countdown, so issue-time wakeups can carry a producer latency.
- Supports cancellation of speculative (load-hit-predicted) wakeups.
- Clears the whole table by a multi-cycle sweep on reset or pipeline flush, with a busy handshake to the dispatch stage.

Parameters:
SRC_OP_NUM, 2, source operands per dispatched op
REG_NUM_BIT_WIDTH, 6, physical register index width
ENTRY_NUM, 64, table entries (= 1<<REG_NUM_BIT_WIDTH, multiple of SWEEP_WIDTH)
DISPATCH_WIDTH, 2, dispatch lanes
WAKEUP_WIDTH, 2, wakeup broadcast ports
CANCEL_WIDTH, 1, speculative-wakeup cancel ports
LAT_BIT_WIDTH, 3, latency field width (latency 0..2^LAT_BIT_WIDTH-1)
SWEEP_WIDTH, 8, entries cleared per sweep cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  when high, wakeups are ignored
flush  in  1  single-cycle pulse; starts a clearing sweep
busy  out  1  sweep in progress; dispatch must hold
wakeup  in  [WAKEUP_WIDTH]  wakeup valid
wakeupDstRegNum  in  [WAKEUP_WIDTH] x REG_NUM_BIT_WIDTH  woken register
wakeupLatency  in  [WAKEUP_WIDTH] x LAT_BIT_WIDTH  cycles until value available
wakeupSpec  in  [WAKEUP_WIDTH]  wakeup is speculative (cancellable)
cancel  in  [CANCEL_WIDTH]  cancel valid
cancelRegNum  in  [CANCEL_WIDTH] x REG_NUM_BIT_WIDTH  register whose speculative wakeup is revoked
dispatch  in  [DISPATCH_WIDTH]  lane valid
dispatchedDstValid  in  [DISPATCH_WIDTH]  destination present
dispatchedDstRegNum  in  [DISPATCH_WIDTH] x REG_NUM_BIT_WIDTH  allocated destination
dispatchedSrcValid  in  [DISPATCH_WIDTH][SRC_OP_NUM]  source present
dispatchedSrcRegNum  in  [DISPATCH_WIDTH][SRC_OP_NUM] x REG_NUM_BIT_WIDTH  source register
dispatchedSrcReady  out  [DISPATCH_WIDTH][SRC_OP_NUM]  source ready (combinational)

Behaviour:
- Entry state: ready bit, spec bit, cnt (LAT_BIT_WIDTH). The entry is PENDING when ready=0 and cnt!=0.
- FSM states:
  - SWEEP: entered while rst is high (idx held at 0, busy=1) and on flush from IDLE.
    - Each cycle with rst low, entries idx..idx+SWEEP_WIDTH-1 are set to ready=1, spec=0, cnt=0, and idx += SWEEP_WIDTH.
    - After the last group, the next state is IDLE.
    - Sweep length after rst drops or after the flush cycle is ENTRY_NUM/SWEEP_WIDTH cycles.
    - rst asserted mid-sweep restarts at idx 0.
    - flush during SWEEP restarts at idx 0.
  - IDLE: busy=0.
- busy is 1 in the reset cycle and in every SWEEP cycle; it is combinationally 1 in the flush cycle itself.
- While busy: dispatch, wakeup and cancel writes are suppressed, and dispatchedSrcReady is don't-care.
- Wakeup at cycle t (wakeup[k] high, stall low), latency L:
  - L=0: dispatchedSrcReady reads TRUE at t via bypass; stored ready=1 from t+1.
  - L=1: stored ready=1 from t+1.
  - L>=2: stored cnt=L-1 at t+1; cnt decrements each cycle; the cycle after cnt==1, ready=1 and cnt=0. The read is TRUE from cycle t+L.
  - spec is stored as wakeupSpec. A non-spec wakeup clears spec.
- Cancel at cycle t: if the entry has spec=1, it goes to ready=0, cnt=0, spec=0 at t+1 and reads FALSE from t. Cancel on a non-spec entry is ignored.
- Dispatch with dispatchedDstValid: the entry goes to ready=0, cnt=0, spec=0.
- Per-entry write priority in one cycle, highest first: sweep > dispatch > cancel > wakeup > countdown.
  - Among wakeup ports to the same register, the lowest index wins.
- Read path for source j of lane i:
  - FALSE-valid source gives TRUE.
  - Otherwise start from the stored ready bit.
  - OR in same-cycle L=0 wakeups to the same register.
  - Force FALSE on a same-cycle cancel hit (entry spec=1, or a same-cycle spec wakeup to that register).
  - Force FALSE if any lane k<i dispatches the same register as destination.
- Countdown saturates at 0 and does not underflow.

Decomposition:
- Shared package (SchedulerTypes):
  - ReadyLatencyEntry struct {ready, spec, cnt}
  - LatencyPath typedef
  - ReadyTableState enum {RLT_SWEEP, RLT_IDLE}
  - WAKEUP/CANCEL width constants
- One sub-module, ready_latency_entry: per-entry next-state logic (priority merge plus countdown), instantiated ENTRY_NUM times.

Test Plan:
- rst high 3 cycles, then low -> busy=1 for 3+8 cycles, then 0; all 64 sources read TRUE.
- Dispatch dst r5; next cycle wakeup r5 L=3 non-spec at t=10 -> src r5 reads FALSE at 10–12, TRUE at 13 onward.
- Wakeup r7 L=0 at t, same-cycle src r7 on lane 1 -> TRUE at t; with lane 0 dispatching dst r7 in the same cycle -> FALSE.
- Spec wakeup r9 L=1 at t, cancel r9 at t+2 -> TRUE at t+1, FALSE at t+2 onward; repeat with a non-spec wakeup -> cancel ignored, stays TRUE.
- Wakeup r3 L=4 with stall high -> ignored, r3 stays FALSE.
- Flush at t with r4 pending (cnt=3) -> busy 1 from t through t+8, r4 reads TRUE after the sweep; dispatch during busy does not clear r12.

Source files
------------

// File: rtl/ready_latency_table_pkg.sv
// Shared scheduler types for the latency-aware ready table: widths, entry layout
// and sweep FSM states.
package ready_latency_table_pkg;

  localparam int SRC_OP_NUM        = 2;
  localparam int REG_NUM_BIT_WIDTH = 6;
  localparam int ENTRY_NUM         = 1 << REG_NUM_BIT_WIDTH;
  localparam int DISPATCH_WIDTH    = 2;
  localparam int WAKEUP_WIDTH      = 2;
  localparam int CANCEL_WIDTH      = 1;
  localparam int LAT_BIT_WIDTH     = 3;
  localparam int SWEEP_WIDTH       = 8;

  localparam int SWEEP_GROUP_NUM     = ENTRY_NUM / SWEEP_WIDTH;
  localparam int SWEEP_IDX_BIT_WIDTH = $clog2(SWEEP_GROUP_NUM);

  typedef logic [REG_NUM_BIT_WIDTH-1:0]   RegNumPath;
  typedef logic [LAT_BIT_WIDTH-1:0]       LatencyPath;
  typedef logic [SWEEP_IDX_BIT_WIDTH-1:0] SweepIdxPath;

  typedef struct packed {
    logic       ready;
    logic       spec;
    LatencyPath cnt;
  } ReadyLatencyEntry;

  typedef enum logic {
    RLT_SWEEP,
    RLT_IDLE
  } ReadyTableState;

endpackage

// File: rtl/ready_latency_table_if.sv
// Dispatch/wakeup/cancel bundle between the scheduler front end (master) and
// the ready latency table (slave).
interface ready_latency_table_if;
  import ready_latency_table_pkg::*;

  logic                                         stall;
  logic                                         flush;
  logic                                         busy;
  logic      [WAKEUP_WIDTH-1:0]                 wakeup;
  RegNumPath [WAKEUP_WIDTH-1:0]                 wakeupDstRegNum;
  LatencyPath [WAKEUP_WIDTH-1:0]                wakeupLatency;
  logic      [WAKEUP_WIDTH-1:0]                 wakeupSpec;
  logic      [CANCEL_WIDTH-1:0]                 cancel;
  RegNumPath [CANCEL_WIDTH-1:0]                 cancelRegNum;
  logic      [DISPATCH_WIDTH-1:0]               dispatch;
  logic      [DISPATCH_WIDTH-1:0]               dispatchedDstValid;
  RegNumPath [DISPATCH_WIDTH-1:0]               dispatchedDstRegNum;
  logic      [DISPATCH_WIDTH-1:0][SRC_OP_NUM-1:0] dispatchedSrcValid;
  RegNumPath [DISPATCH_WIDTH-1:0][SRC_OP_NUM-1:0] dispatchedSrcRegNum;
  logic      [DISPATCH_WIDTH-1:0][SRC_OP_NUM-1:0] dispatchedSrcReady;

  modport master (
    output stall, flush, wakeup, wakeupDstRegNum, wakeupLatency, wakeupSpec,
           cancel, cancelRegNum, dispatch, dispatchedDstValid, dispatchedDstRegNum,
           dispatchedSrcValid, dispatchedSrcRegNum,
    input  busy, dispatchedSrcReady
  );

  modport slave (
    input  stall, flush, wakeup, wakeupDstRegNum, wakeupLatency, wakeupSpec,
           cancel, cancelRegNum, dispatch, dispatchedDstValid, dispatchedDstRegNum,
           dispatchedSrcValid, dispatchedSrcRegNum,
    output busy, dispatchedSrcReady
  );

endinterface

// File: rtl/ready_latency_table_entry.sv
// One table entry: merges sweep/dispatch/cancel/wakeup writes by priority and
// runs the latency countdown when no write lands.
module ready_latency_entry
  import ready_latency_table_pkg::*;
(
  input  logic       clk,
  input  logic       sweep,
  input  logic       dispatchHit,
  input  logic       cancelHit,
  input  logic       wakeupHit,
  input  LatencyPath wakeupLatency,
  input  logic       wakeupSpec,
  output logic       ready,
  output logic       spec
);

  ReadyLatencyEntry entryReg, entryNext;

  always_comb begin
    entryNext = entryReg;
    if (sweep) begin
      entryNext = '{ready: 1'b1, spec: 1'b0, cnt: '0};
    end else if (dispatchHit || cancelHit) begin
      entryNext = '{ready: 1'b0, spec: 1'b0, cnt: '0};
    end else if (wakeupHit) begin
      entryNext.spec = wakeupSpec;
      // Latency 0 and 1 both land as ready next cycle; longer ones count down.
      if (wakeupLatency <= LatencyPath'(1)) begin
        entryNext.ready = 1'b1;
        entryNext.cnt   = '0;
      end else begin
        entryNext.ready = 1'b0;
        entryNext.cnt   = wakeupLatency - LatencyPath'(1);
      end
    end else if (!entryReg.ready && entryReg.cnt != '0) begin
      if (entryReg.cnt == LatencyPath'(1)) begin
        entryNext.ready = 1'b1;
        entryNext.cnt   = '0;
      end else begin
        entryNext.cnt = entryReg.cnt - LatencyPath'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    entryReg <= entryNext;
  end

  assign ready = entryReg.ready;
  assign spec  = entryReg.spec;

endmodule

// File: rtl/ready_latency_table.sv
// Per-physical-register ready table with wakeup latency countdown, speculative
// wakeup cancel, and a group-at-a-time clearing sweep on reset or flush.
module ready_latency_table
  import ready_latency_table_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  ready_latency_table_if.slave  tableIf
);

  ReadyTableState stateReg, stateNext;
  SweepIdxPath    idxReg, idxNext;
  logic           busy;
  logic           sweepWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= RLT_SWEEP;
      idxReg   <= '0;
    end else begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    case (stateReg)
      RLT_IDLE: begin
        if (tableIf.flush) begin
          stateNext = RLT_SWEEP;
          idxNext   = '0;
        end
      end
      RLT_SWEEP: begin
        if (tableIf.flush) begin
          idxNext = '0;
        end else if (idxReg == SweepIdxPath'(SWEEP_GROUP_NUM - 1)) begin
          stateNext = RLT_IDLE;
          idxNext   = '0;
        end else begin
          idxNext = idxReg + SweepIdxPath'(1);
        end
      end
      default: stateNext = RLT_SWEEP;
    endcase
  end

  // Flush raises busy in its own cycle so dispatch holds before the sweep starts.
  always_comb begin
    sweepWrite = (stateReg == RLT_SWEEP) && !rst;
    busy       = rst || (stateReg == RLT_SWEEP) || tableIf.flush;
  end

  assign tableIf.busy = busy;

  logic [WAKEUP_WIDTH-1:0] wakeupEn;
  assign wakeupEn = tableIf.wakeup & {WAKEUP_WIDTH{!tableIf.stall}};

  logic [ENTRY_NUM-1:0] readyVec, specVec, bypassVec, cancelVec;

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : gEntry
    logic       dispatchHit, wakeupHit, wakeupSpec, specWakeup, bypass, cancelMatch;
    LatencyPath wakeupLatency;

    always_comb begin
      dispatchHit   = 1'b0;
      wakeupHit     = 1'b0;
      wakeupLatency = '0;
      wakeupSpec    = 1'b0;
      specWakeup    = 1'b0;
      bypass        = 1'b0;
      cancelMatch   = 1'b0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (tableIf.dispatch[k] && tableIf.dispatchedDstValid[k] &&
            tableIf.dispatchedDstRegNum[k] == RegNumPath'(gi))
          dispatchHit = 1'b1;
      end
      // Scan downward so the lowest-index matching port is the one kept.
      for (int k = WAKEUP_WIDTH - 1; k >= 0; k--) begin
        if (wakeupEn[k] && tableIf.wakeupDstRegNum[k] == RegNumPath'(gi)) begin
          wakeupHit     = 1'b1;
          wakeupLatency = tableIf.wakeupLatency[k];
          wakeupSpec    = tableIf.wakeupSpec[k];
        end
      end
      for (int k = 0; k < WAKEUP_WIDTH; k++) begin
        if (wakeupEn[k] && tableIf.wakeupDstRegNum[k] == RegNumPath'(gi)) begin
          if (tableIf.wakeupSpec[k]) specWakeup = 1'b1;
          if (tableIf.wakeupLatency[k] == '0) bypass = 1'b1;
        end
      end
      for (int c = 0; c < CANCEL_WIDTH; c++) begin
        if (tableIf.cancel[c] && tableIf.cancelRegNum[c] == RegNumPath'(gi) &&
            (specVec[gi] || specWakeup))
          cancelMatch = 1'b1;
      end
    end

    assign bypassVec[gi] = bypass;
    assign cancelVec[gi] = cancelMatch;

    ready_latency_entry entry (
      .clk           (clk),
      .sweep         (sweepWrite && idxReg == SweepIdxPath'(gi / SWEEP_WIDTH)),
      .dispatchHit   (dispatchHit && !busy),
      .cancelHit     (cancelMatch && !busy),
      .wakeupHit     (wakeupHit && !busy),
      .wakeupLatency (wakeupLatency),
      .wakeupSpec    (wakeupSpec),
      .ready         (readyVec[gi]),
      .spec          (specVec[gi])
    );
  end

  for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : gLane
    for (genvar gj = 0; gj < SRC_OP_NUM; gj++) begin : gSrc
      RegNumPath srcReg;
      logic      olderDstHit;
      assign srcReg = tableIf.dispatchedSrcRegNum[gi][gj];

      // An older lane in the same bundle that reallocates this register wins.
      always_comb begin
        olderDstHit = 1'b0;
        for (int k = 0; k < gi; k++) begin
          if (tableIf.dispatch[k] && tableIf.dispatchedDstValid[k] &&
              tableIf.dispatchedDstRegNum[k] == srcReg)
            olderDstHit = 1'b1;
        end
      end

      assign tableIf.dispatchedSrcReady[gi][gj] =
          !tableIf.dispatchedSrcValid[gi][gj] ||
          ((readyVec[srcReg] || bypassVec[srcReg]) && !cancelVec[srcReg] && !olderDstHit);
    end
  end

endmodule
